// File: rtl/rect_overlay.sv
// Multi-slot rectangle overlay: double-buffered slot registers, per-slot hit test,
// two-stage pipeline that resolves the highest-priority (lowest index) hit to a colour.

module rect_hit #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          i_en,
    input  logic          i_outline,
    input  logic [XW-1:0] i_x0,
    input  logic [YW-1:0] i_y0,
    input  logic [XW-1:0] i_w,
    input  logic [YW-1:0] i_h,
    input  logic [XW-1:0] i_px,
    input  logic [YW-1:0] i_py,
    output logic          o_hit
);
    // One extra bit so x0+w never wraps back into the visible range.
    logic [XW:0] w_xe, w_px, w_x0;
    logic [YW:0] w_ye, w_py, w_y0;
    logic        w_inside, w_edge;

    assign w_px = {1'b0, i_px};
    assign w_py = {1'b0, i_py};
    assign w_x0 = {1'b0, i_x0};
    assign w_y0 = {1'b0, i_y0};
    assign w_xe = w_x0 + {1'b0, i_w};
    assign w_ye = w_y0 + {1'b0, i_h};

    assign w_inside = (w_px >= w_x0) && (w_px < w_xe) && (w_py >= w_y0) && (w_py < w_ye);
    assign w_edge   = (w_px == w_x0) || (w_px == w_xe - (XW+1)'(1)) ||
                      (w_py == w_y0) || (w_py == w_ye - (YW+1)'(1));
    assign o_hit    = i_en && w_inside && (!i_outline || w_edge);
endmodule

module rect_overlay #(
    parameter int             NUM_RECT = 4,
    parameter int             XW       = 10,
    parameter int             YW       = 9,
    parameter logic [7:0]     BG_VALUE = 8'd0,
    // Slot index is one bit wider than strictly needed so out-of-range slots are expressible.
    localparam int            SW       = $clog2(NUM_RECT + 1)
) (
    input  logic          cclk,
    input  logic          rstb,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [SW-1:0] i_wr_slot,
    input  logic          i_wr_en,
    input  logic          i_wr_outline,
    input  logic [XW-1:0] i_wr_x,
    input  logic [YW-1:0] i_wr_y,
    input  logic [XW-1:0] i_wr_w,
    input  logic [YW-1:0] i_wr_h,
    input  logic [7:0]    i_wr_color,
    input  logic          i_frame_start,
    input  logic          i_pix_valid,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic          o_tft_valid,
    output logic [7:0]    o_tft_value
);
    typedef struct packed {
        logic          en;
        logic          outline;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [7:0]    color;
    } slot_t;

    slot_t r_pend [NUM_RECT];
    slot_t r_act  [NUM_RECT];
    slot_t w_view [NUM_RECT];
    slot_t w_wr_data;

    logic                         w_wr_fire;
    logic [NUM_RECT-1:0]          w_hit;
    logic [NUM_RECT-1:0]          r_s1_hit;
    logic [NUM_RECT-1:0][7:0]     r_s1_col;
    logic [1:0]                   r_vld_pipe;
    logic [7:0]                   w_sel;
    logic [7:0]                   r_tft_value;

    assign o_wr_ready = rstb & ~i_frame_start;
    assign w_wr_fire  = i_wr_valid & o_wr_ready;
    assign w_wr_data  = '{en: i_wr_en, outline: i_wr_outline, x: i_wr_x, y: i_wr_y,
                          w: i_wr_w, h: i_wr_h, color: i_wr_color};

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_RECT; i++) begin
                r_pend[i] <= '0;
                r_act[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RECT; i++) begin
                if (w_wr_fire && i_wr_slot == SW'(i))
                    r_pend[i] <= w_wr_data;
            end
            if (i_frame_start)
                r_act <= r_pend;
        end
    end

    // The pixel that arrives with frame_start already belongs to the new frame.
    genvar g;
    generate
        for (g = 0; g < NUM_RECT; g++) begin : g_slot
            assign w_view[g] = i_frame_start ? r_pend[g] : r_act[g];
            rect_hit #(.XW(XW), .YW(YW)) u_hit (
                .i_en     (w_view[g].en),
                .i_outline(w_view[g].outline),
                .i_x0     (w_view[g].x),
                .i_y0     (w_view[g].y),
                .i_w      (w_view[g].w),
                .i_h      (w_view[g].h),
                .i_px     (i_x),
                .i_py     (i_y),
                .o_hit    (w_hit[g])
            );
        end
    endgenerate

    // Colours travel with the hit vector so a commit cannot recolour a pixel in flight.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            r_s1_hit    <= '0;
            r_s1_col    <= '0;
            r_vld_pipe  <= '0;
            r_tft_value <= BG_VALUE;
        end else begin
            r_s1_hit    <= w_hit & {NUM_RECT{i_pix_valid}};
            for (int i = 0; i < NUM_RECT; i++)
                r_s1_col[i] <= w_view[i].color;
            r_vld_pipe  <= {r_vld_pipe[0], i_pix_valid};
            r_tft_value <= w_sel;
        end
    end

    always_comb begin
        w_sel = BG_VALUE;
        for (int i = NUM_RECT - 1; i >= 0; i--)
            if (r_s1_hit[i]) w_sel = r_s1_col[i];
    end

    assign o_tft_valid = r_vld_pipe[1];
    assign o_tft_value = r_tft_value;
endmodule

// File: tb/tb_rect_overlay.sv
// Scoreboard bench for rect_overlay: directed scenarios then random traffic,
// checked against a slot-list reference model.

module tb_rect_overlay;
    localparam int         NR = 4;
    localparam int         XW = 10;
    localparam int         YW = 9;
    localparam int         SW = 3;
    localparam logic [7:0] BG = 8'd0;

    logic          cclk, rstb;
    logic          i_wr_valid, o_wr_ready;
    logic [SW-1:0] i_wr_slot;
    logic          i_wr_en, i_wr_outline;
    logic [XW-1:0] i_wr_x, i_wr_w;
    logic [YW-1:0] i_wr_y, i_wr_h;
    logic [7:0]    i_wr_color;
    logic          i_frame_start, i_pix_valid;
    logic [XW-1:0] i_x;
    logic [YW-1:0] i_y;
    logic          o_tft_valid;
    logic [7:0]    o_tft_value;

    rect_overlay #(.NUM_RECT(NR), .XW(XW), .YW(YW), .BG_VALUE(BG)) dut (
        .cclk(cclk), .rstb(rstb),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_slot(i_wr_slot),
        .i_wr_en(i_wr_en), .i_wr_outline(i_wr_outline),
        .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_wr_w(i_wr_w), .i_wr_h(i_wr_h),
        .i_wr_color(i_wr_color), .i_frame_start(i_frame_start),
        .i_pix_valid(i_pix_valid), .i_x(i_x), .i_y(i_y),
        .o_tft_valid(o_tft_valid), .o_tft_value(o_tft_value)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    typedef struct { bit en; bit ol; int x; int y; int w; int h; int col; } mslot_t;
    typedef struct { int val; int stamp; } exp_t;

    mslot_t m_pend [NR];
    mslot_t m_act  [NR];
    exp_t   q [$];
    exp_t   mon_e;
    int     cyc = 0, n_cmp = 0, n_err = 0;
    bit     mon_en = 0;

    // Reference: first enabled slot, in index order, whose rectangle covers the pixel.
    function automatic int ref_pix(bit use_pend, int px, int py);
        mslot_t s;
        for (int i = 0; i < NR; i++) begin
            s = use_pend ? m_pend[i] : m_act[i];
            if (s.en && px >= s.x && px < s.x + s.w && py >= s.y && py < s.y + s.h)
                if (!s.ol || px == s.x || px == s.x + s.w - 1 || py == s.y || py == s.y + s.h - 1)
                    return s.col;
        end
        return int'(BG);
    endfunction

    always @(posedge cclk) begin
        cyc++;
        n_cmp++;
        if (o_wr_ready !== (rstb && !i_frame_start)) begin
            n_err++;
            $display("FAIL wr_ready cyc=%0d got=%b want=%b", cyc, o_wr_ready, rstb && !i_frame_start);
        end
        if (!rstb) begin
            q.delete();
            for (int i = 0; i < NR; i++) begin
                m_pend[i] = '{default: 0};
                m_act[i]  = '{default: 0};
            end
        end else begin
            if (i_pix_valid)
                q.push_back('{ref_pix(i_frame_start, int'(i_x), int'(i_y)), cyc});
            if (i_wr_valid && !i_frame_start && int'(i_wr_slot) < NR)
                m_pend[i_wr_slot] = '{i_wr_en, i_wr_outline, int'(i_wr_x), int'(i_wr_y),
                                      int'(i_wr_w), int'(i_wr_h), int'(i_wr_color)};
            if (i_frame_start)
                m_act = m_pend;
        end
    end

    always @(posedge cclk) begin
        #1;
        if (mon_en) begin
            if (o_tft_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pixel cyc=%0d got=%h want=none", cyc, o_tft_value);
                end else begin
                    mon_e = q.pop_front();
                    if (o_tft_value !== 8'(mon_e.val) || mon_e.stamp != cyc - 1) begin
                        n_err++;
                        $display("FAIL pixel cyc=%0d got=%h want=%h issued=%0d want_issued=%0d",
                                 cyc, o_tft_value, 8'(mon_e.val), mon_e.stamp, cyc - 1);
                    end
                end
            end else begin
                n_cmp++;
                if (o_tft_valid !== 1'b0 || o_tft_value !== BG) begin
                    n_err++;
                    $display("FAIL idle cyc=%0d got valid=%b value=%h want 0/%h",
                             cyc, o_tft_valid, o_tft_value, BG);
                end
            end
        end
    end

    task automatic step();
        @(negedge cclk);
        i_frame_start = 1'b0;
    endtask

    task automatic pix(int px, int py);
        i_pix_valid = 1'b1;
        i_x = XW'(px);
        i_y = YW'(py);
        step();
    endtask

    task automatic idle(int n);
        i_pix_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic frame();
        i_frame_start = 1'b1;
        step();
    endtask

    task automatic wr(int s, bit en, bit ol, int x, int y, int w, int h, int col);
        bit acc = 0;
        i_wr_slot = SW'(s); i_wr_en = en; i_wr_outline = ol;
        i_wr_x = XW'(x); i_wr_y = YW'(y); i_wr_w = XW'(w); i_wr_h = YW'(h);
        i_wr_color = 8'(col);
        i_wr_valid = 1'b1;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(posedge cclk);
            acc = o_wr_ready;
            step();
        end
        i_wr_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL wr_timeout slot=%0d got=no_accept want=accept", s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 0; i_wr_valid = 0; i_wr_slot = '0; i_wr_en = 0; i_wr_outline = 0;
        i_wr_x = '0; i_wr_y = '0; i_wr_w = '0; i_wr_h = '0; i_wr_color = '0;
        i_frame_start = 0; i_pix_valid = 0; i_x = '0; i_y = '0;
        @(posedge cclk);
        mon_en = 1;
        repeat (3) step();
        rstb = 1;
        idle(2);

        // Filled rectangle scan
        wr(0, 1, 0, 10, 20, 5, 3, 8'hAA);
        frame();
        for (int x = 9; x <= 15; x++) pix(x, 20);
        pix(12, 22); pix(12, 23);
        idle(3);

        // Reset in the middle of a pixel stream
        for (int x = 9; x <= 12; x++) pix(x, 20);
        i_pix_valid = 1; rstb = 0;
        repeat (3) step();
        rstb = 1;
        for (int x = 9; x <= 15; x++) pix(x, 20);
        idle(3);

        // Outline
        wr(1, 1, 1, 0, 0, 4, 4, 8'h55);
        frame();
        pix(0, 0); pix(3, 2); pix(1, 3); pix(1, 1); pix(2, 2); pix(4, 0);
        idle(3);

        // Priority / overlap
        wr(0, 1, 0, 0, 0, 8, 8, 8'h11);
        wr(2, 1, 0, 4, 4, 8, 8, 8'h22);
        frame();
        pix(5, 5); pix(9, 9); pix(2, 9);
        idle(2);

        // Double buffering: mid-frame write is invisible until commit; write held across commit
        wr(0, 1, 0, 0, 0, 8, 8, 8'h33);
        pix(5, 5); pix(5, 5);
        i_frame_start = 1; i_pix_valid = 1; i_x = 10'd5; i_y = 9'd5;
        wr(2, 1, 0, 4, 4, 8, 8, 8'h44);
        pix(9, 9); pix(5, 5);
        frame();
        pix(9, 9);
        idle(3);

        // Right-edge clipping without wrap, zero width, out-of-range slot
        wr(0, 0, 0, 0, 0, 0, 0, 0);
        wr(1, 0, 0, 0, 0, 0, 0, 0);
        wr(2, 0, 0, 0, 0, 0, 0, 0);
        wr(3, 1, 0, 1020, 0, 10, 2, 8'h77);
        frame();
        for (int x = 1016; x <= 1023; x++) pix(x, 0);
        for (int x = 0; x <= 5; x++) pix(x, 0);
        wr(3, 1, 0, 1020, 0, 0, 2, 8'h77);
        wr(7, 1, 0, 0, 0, 50, 50, 8'h99);
        frame();
        pix(1020, 0); pix(3, 3); pix(10, 10);
        idle(3);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            i_wr_valid = ($urandom % 4) == 0;
            i_wr_slot = SW'($urandom % 8);
            i_wr_en = ($urandom % 5) != 0;
            i_wr_outline = ($urandom % 3) == 0;
            if ($urandom % 6 == 0) begin
                i_wr_x = XW'(1000 + $urandom % 24); i_wr_w = XW'($urandom % 40);
                i_wr_y = YW'(500 + $urandom % 12);  i_wr_h = YW'($urandom % 20);
            end else begin
                i_wr_x = XW'($urandom % 40); i_wr_w = XW'($urandom % 16);
                i_wr_y = YW'($urandom % 40); i_wr_h = YW'($urandom % 16);
            end
            i_wr_color = 8'($urandom);
            i_frame_start = ($urandom % 25) == 0;
            i_pix_valid = ($urandom % 4) != 0;
            if ($urandom % 6 == 0) begin
                i_x = XW'(1000 + $urandom % 24); i_y = YW'(500 + $urandom % 12);
            end else begin
                i_x = XW'($urandom % 48); i_y = YW'($urandom % 48);
            end
            @(negedge cclk);
        end
        i_wr_valid = 0; i_frame_start = 0;
        idle(5);

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d_outstanding want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
